// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. Issues one imem request
// at a time, buffers a returned word under stall, and squashes work on redirect.
module if_fetch_stage #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter int                PC_INC   = 4
) (
    input  logic               CLK,
    input  logic               Reset_L,
    input  logic               PC_WriteEn,
    input  logic               IFID_WriteEn,
    input  logic               Branch_Taken,
    input  logic [ADDR_W-1:0]  Branch_Target,
    output logic               Imem_Req,
    output logic [ADDR_W-1:0]  Imem_Addr,
    input  logic               Imem_Ready,
    input  logic               Imem_RValid,
    input  logic [INSTR_W-1:0] Imem_RData,
    output logic [ADDR_W-1:0]  IFID_PC,
    output logic [INSTR_W-1:0] IFID_Instr,
    output logic               IFID_Valid
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                kill_q, kill_d;
    logic [INSTR_W-1:0]  buf_q, buf_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   ifid_pc_q, ifid_pc_d;
    logic [INSTR_W-1:0]  ifid_instr_q, ifid_instr_d;
    logic                ifid_valid_q, ifid_valid_d;

    logic                req_fire_s;
    logic                available_s;
    logic                advance_s;
    logic [INSTR_W-1:0]  word_s;

    // Request is registered and only counts as accepted once it is actually driven.
    assign req_fire_s  = req_q & Imem_Ready;
    assign available_s = (state_q == ST_HOLD) |
                         ((state_q == ST_WAIT) & Imem_RValid & ~kill_q);
    assign advance_s   = available_s & PC_WriteEn & IFID_WriteEn;
    assign word_s      = (state_q == ST_HOLD) ? buf_q : Imem_RData;
    assign req_d       = (state_d == ST_FETCH);

    // Next-state, PC, holding buffer and IF/ID update; redirect overrides everything.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        buf_d        = buf_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;

        if (Branch_Taken) begin
            pc_d         = Branch_Target;
            ifid_instr_d = {INSTR_W{1'b0}};
            ifid_valid_d = 1'b0;
            buf_d        = {INSTR_W{1'b0}};
            case (state_q)
                ST_FETCH: begin
                    if (req_fire_s) begin
                        kill_d  = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        kill_d  = 1'b0;
                        state_d = ST_FETCH;
                    end
                end
                ST_WAIT: begin
                    if (Imem_RValid) begin
                        kill_d  = 1'b0;
                        state_d = ST_FETCH;
                    end else begin
                        kill_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    kill_d  = 1'b0;
                    state_d = ST_FETCH;
                end
            endcase
        end else if (available_s) begin
            if (advance_s) begin
                ifid_pc_d    = pc_q;
                ifid_instr_d = word_s;
                ifid_valid_d = 1'b1;
                pc_d         = pc_q + ADDR_W'(PC_INC);
                state_d      = ST_FETCH;
            end else begin
                buf_d   = word_s;
                state_d = ST_HOLD;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (req_fire_s) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_WAIT: begin
                    // A killed response is swallowed here; stray data outside WAIT never reaches this path.
                    if (Imem_RValid & kill_q) begin
                        kill_d  = 1'b0;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
            if (IFID_WriteEn) begin
                ifid_instr_d = {INSTR_W{1'b0}};
                ifid_valid_d = 1'b0;
            end else begin
                ifid_instr_d = ifid_instr_q;
                ifid_valid_d = ifid_valid_q;
            end
        end
    end

    // State and datapath registers; reset drops any outstanding request.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            buf_q        <= {INSTR_W{1'b0}};
            req_q        <= 1'b0;
            ifid_pc_q    <= {ADDR_W{1'b0}};
            ifid_instr_q <= {INSTR_W{1'b0}};
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            buf_q        <= buf_d;
            req_q        <= req_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign Imem_Req   = req_q;
    assign Imem_Addr  = pc_q;
    assign IFID_PC    = ifid_pc_q;
    assign IFID_Instr = ifid_instr_q;
    assign IFID_Valid = ifid_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: expected request addresses and IF/ID loads
// are queued by the stimulus and checked by an independent negedge monitor.
module tb_if_fetch_stage;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic        PC_WriteEn;
    logic        IFID_WriteEn;
    logic        Branch_Taken;
    logic [63:0] Branch_Target;
    logic        Imem_Req;
    logic [63:0] Imem_Addr;
    logic        Imem_Ready;
    logic        Imem_RValid;
    logic [31:0] Imem_RData;
    logic [63:0] IFID_PC;
    logic [31:0] IFID_Instr;
    logic        IFID_Valid;

    int tests  = 0;
    int failed = 0;

    logic [63:0] exp_addr_q[$];
    logic [63:0] exp_pc_q[$];
    logic [31:0] exp_instr_q[$];

    logic        prev_valid = 1'b0;
    logic [63:0] prev_pc    = 64'd0;

    if_fetch_stage #(
        .ADDR_W  (64),
        .INSTR_W (32),
        .RESET_PC(64'h100),
        .PC_INC  (4)
    ) dut (
        .CLK          (CLK),
        .Reset_L      (Reset_L),
        .PC_WriteEn   (PC_WriteEn),
        .IFID_WriteEn (IFID_WriteEn),
        .Branch_Taken (Branch_Taken),
        .Branch_Target(Branch_Target),
        .Imem_Req     (Imem_Req),
        .Imem_Addr    (Imem_Addr),
        .Imem_Ready   (Imem_Ready),
        .Imem_RValid  (Imem_RValid),
        .Imem_RData   (Imem_RData),
        .IFID_PC      (IFID_PC),
        .IFID_Instr   (IFID_Instr),
        .IFID_Valid   (IFID_Valid)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Hold Imem_Ready until the DUT requests, then let one edge accept it.
    task automatic accept(input logic [63:0] a);
        int n = 0;
        exp_addr_q.push_back(a);
        Imem_Ready = 1'b1;
        while (!Imem_Req && n < 10) begin
            step();
            n++;
        end
        if (!Imem_Req) begin
            tests++;
            failed++;
            $display("FAIL req_timeout: Imem_Req got 0 expected 1");
        end
        step();
        Imem_Ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d, input logic [63:0] pc);
        exp_pc_q.push_back(pc);
        exp_instr_q.push_back(d);
        Imem_RValid = 1'b1;
        Imem_RData  = d;
        step();
        Imem_RValid = 1'b0;
    endtask

    // Monitor: every accepted request and every newly loaded IF/ID entry is scored.
    always @(negedge CLK) begin
        if (Reset_L) begin
            if (Imem_Req && Imem_Ready) begin
                if (exp_addr_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_req: got addr %h expected no request", Imem_Addr);
                end else begin
                    chk("req_addr", Imem_Addr, exp_addr_q.pop_front());
                end
            end
            if (IFID_Valid && (!prev_valid || IFID_PC != prev_pc)) begin
                if (exp_pc_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_ifid: got pc %h instr %h expected none", IFID_PC, IFID_Instr);
                end else begin
                    chk("ifid_pc", IFID_PC, exp_pc_q.pop_front());
                    chk("ifid_instr", 64'(IFID_Instr), 64'(exp_instr_q.pop_front()));
                end
            end
        end
        prev_valid <= IFID_Valid;
        prev_pc    <= IFID_PC;
    end

    initial begin
        Reset_L       = 1'b0;
        PC_WriteEn    = 1'b1;
        IFID_WriteEn  = 1'b1;
        Branch_Taken  = 1'b0;
        Branch_Target = 64'd0;
        Imem_Ready    = 1'b0;
        Imem_RValid   = 1'b0;
        Imem_RData    = 32'd0;
        step();
        step();
        chk("rst_req", 64'(Imem_Req), 64'd0);
        chk("rst_addr", Imem_Addr, 64'h100);
        chk("rst_ifid_valid", 64'(IFID_Valid), 64'd0);
        chk("rst_ifid_pc", IFID_PC, 64'd0);
        chk("rst_ifid_instr", 64'(IFID_Instr), 64'd0);
        Reset_L = 1'b1;

        // First fetch with minimum latency
        accept(64'h100);
        respond(32'h8B020020, 64'h100);
        chk("lat_ifid_valid", 64'(IFID_Valid), 64'd1);
        chk("lat_next_req", 64'(Imem_Req), 64'd1);
        chk("lat_next_addr", Imem_Addr, 64'h104);

        // Load-use stall as the response arrives
        accept(64'h104);
        PC_WriteEn   = 1'b0;
        IFID_WriteEn = 1'b0;
        Imem_RValid  = 1'b1;
        Imem_RData   = 32'h11111111;
        step();
        Imem_RValid  = 1'b0;
        chk("stall_req", 64'(Imem_Req), 64'd0);
        chk("stall_ifid_pc", IFID_PC, 64'h100);
        chk("stall_ifid_valid", 64'(IFID_Valid), 64'd0);
        PC_WriteEn   = 1'b1;
        IFID_WriteEn = 1'b1;
        exp_pc_q.push_back(64'h104);
        exp_instr_q.push_back(32'h11111111);
        step();
        chk("unstall_req", 64'(Imem_Req), 64'd1);
        chk("unstall_addr", Imem_Addr, 64'h108);

        // Slow memory: not ready for three cycles, two-cycle response
        for (int i = 0; i < 3; i++) begin
            step();
            chk("slow_req", 64'(Imem_Req), 64'd1);
            chk("slow_addr", Imem_Addr, 64'h108);
            chk("slow_bubble", 64'(IFID_Valid), 64'd0);
        end
        accept(64'h108);
        step();
        chk("slow_wait_req", 64'(Imem_Req), 64'd0);
        respond(32'h22222222, 64'h108);

        // Redirect while waiting: late response must be dropped
        accept(64'h10C);
        Branch_Taken  = 1'b1;
        Branch_Target = 64'h200;
        step();
        Branch_Taken  = 1'b0;
        chk("br_wait_valid", 64'(IFID_Valid), 64'd0);
        chk("br_wait_instr", 64'(IFID_Instr), 64'd0);
        chk("br_wait_req", 64'(Imem_Req), 64'd0);
        Imem_RValid = 1'b1;
        Imem_RData  = 32'hDEADBEEF;
        step();
        Imem_RValid = 1'b0;
        chk("br_kill_valid", 64'(IFID_Valid), 64'd0);
        accept(64'h200);
        respond(32'h33333333, 64'h200);

        // Redirect while a stalled word sits in the holding buffer
        accept(64'h204);
        PC_WriteEn  = 1'b0;
        Imem_RValid = 1'b1;
        Imem_RData  = 32'h44444444;
        step();
        Imem_RValid = 1'b0;
        chk("hold_req", 64'(Imem_Req), 64'd0);
        Branch_Taken  = 1'b1;
        Branch_Target = 64'h300;
        step();
        Branch_Taken  = 1'b0;
        PC_WriteEn    = 1'b1;
        chk("br_hold_valid", 64'(IFID_Valid), 64'd0);
        chk("br_hold_addr", Imem_Addr, 64'h300);
        accept(64'h300);
        respond(32'h55555555, 64'h300);

        // Asynchronous reset in the middle of WAIT
        accept(64'h304);
        #2;
        Reset_L = 1'b0;
        #1;
        chk("arst_valid", 64'(IFID_Valid), 64'd0);
        chk("arst_pc", IFID_PC, 64'd0);
        chk("arst_instr", 64'(IFID_Instr), 64'd0);
        chk("arst_req", 64'(Imem_Req), 64'd0);
        step();
        Reset_L     = 1'b1;
        Imem_RValid = 1'b1;
        Imem_RData  = 32'h66666666;
        step();
        Imem_RValid = 1'b0;
        chk("arst_stale_valid", 64'(IFID_Valid), 64'd0);
        accept(64'h100);
        respond(32'h77777777, 64'h100);

        // Redirect of an unaccepted request, then PC wrap-around
        Branch_Taken  = 1'b1;
        Branch_Target = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        Branch_Taken  = 1'b0;
        chk("br_fetch_addr", Imem_Addr, 64'hFFFF_FFFF_FFFF_FFFC);
        accept(64'hFFFF_FFFF_FFFF_FFFC);
        respond(32'h88888888, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_addr", Imem_Addr, 64'd0);
        accept(64'd0);
        step();
        step();

        chk("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
        chk("ifid_q_empty", 64'(exp_pc_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register. Holds the PC and issues one instruction-memory request at a time over a variable-latency ready/valid interface. Writes fetched instructions into IF/ID, which feeds ID and the stall control unit. Obeys the stall unit's PC_WriteEn/IFID_WriteEn, and applies taken-branch redirects from downstream by flushing IF/ID and discarding in-flight fetches.

Parameters:
ADDR_W, 64, PC/address width
INSTR_W, 32, instruction width
RESET_PC, 0, PC value after reset
PC_INC, 4, sequential PC increment

Ports:
CLK  input  1  clock, rising edge
Reset_L  input  1  asynchronous active-low reset
PC_WriteEn  input  1  stall control: 0 freezes PC
IFID_WriteEn  input  1  stall control: 0 holds IF/ID
Branch_Taken  input  1  redirect request, one cycle
Branch_Target  input  ADDR_W  redirect address
Imem_Req  output  1  fetch request valid
Imem_Addr  output  ADDR_W  fetch address
Imem_Ready  input  1  memory accepts request this cycle
Imem_RValid  input  1  read data valid
Imem_RData  input  INSTR_W  instruction word
IFID_PC  output  ADDR_W  PC of instruction in IF/ID
IFID_Instr  output  INSTR_W  instruction in IF/ID
IFID_Valid  output  1  IF/ID holds a real instruction

Behaviour:
- One clock; reset is asynchronous and active-low on Reset_L. Reset forces: PC=RESET_PC, state=FETCH, kill=0, buffer empty, Imem_Req=0 for the reset cycle, IFID_PC=0, IFID_Instr=0, IFID_Valid=0. Asserting reset mid-fetch drops the outstanding request. Any response arriving after reset is ignored.
- States:
  - FETCH: Imem_Req=1, Imem_Addr=PC. On Imem_Ready, go to WAIT.
  - WAIT: Imem_Req=0. On Imem_RValid, the word becomes "available".
  - HOLD: the word is buffered in a one-entry holding register and stays available. Imem_Req=0.
- advance = available & PC_WriteEn & IFID_WriteEn.
  - On advance: IF/ID <= {PC, word, Valid=1}, PC <= PC+PC_INC (wraps modulo 2^ADDR_W), state -> FETCH.
  - If a word is available without advance: buffer it and move to or stay in HOLD. Neither PC nor IF/ID changes.
- IF/ID when not advancing:
  - IFID_WriteEn=1 and nothing available: load bubble (Valid=0, Instr=0; PC field unchanged).
  - IFID_WriteEn=0: hold all fields.
- Minimum latency: Imem_Ready in cycle N, Imem_RValid in N+1 with no stall → IFID_Valid=1 at N+2 edge; next request issues at N+2.
- Branch_Taken has priority over stall and over advance:
  - PC <= Branch_Target.
  - IF/ID <= bubble (Valid=0, Instr=0).
  - Buffer cleared.
  - In FETCH with Imem_Ready the same cycle, or in WAIT without Imem_RValid: set kill and go to WAIT. The next Imem_RValid is discarded, kill clears, and the block returns to FETCH.
  - In WAIT with Imem_RValid the same cycle: discard that word, go to FETCH.
  - Otherwise: go to FETCH.
- Exactly one outstanding request at any time; Imem_Req is never asserted in WAIT or HOLD.
- Imem_Addr is stable while Imem_Req=1 and Imem_Ready=0. Branch_Taken in that window may change it the next cycle, since that request was not accepted.
- Imem_RValid outside WAIT is a protocol error and is ignored.

Test Plan:
- Reset/first fetch: release Reset_L with RESET_PC=0x100, Imem_Ready=1, 1-cycle response 0x8B020020 → Imem_Addr=0x100; IFID_PC=0x100, IFID_Instr=0x8B020020, IFID_Valid=1 two cycles after acceptance; next Imem_Addr=0x104.
- Load-use stall: PC_WriteEn=IFID_WriteEn=0 for 1 cycle as response 0x104 arrives → IF/ID keeps 0x100 instruction, word buffered (HOLD, Imem_Req=0); enables back to 1 → IFID_PC=0x104, next Imem_Addr=0x108.
- Slow memory: Imem_Ready low 3 cycles, response 2 cycles after acceptance → Imem_Addr held at 0x108 throughout; IF/ID receives bubbles (Valid=0) while waiting; one request only.
- Redirect in flight: Branch_Taken=1, target 0x200, while in WAIT → IF/ID bubble next edge; the late response for 0x10C is discarded; next request Imem_Addr=0x200; IFID_PC=0x200 after its response.
- Redirect during stall: Branch_Taken=1 with PC_WriteEn=0 in HOLD → buffer dropped, PC=target, IFID_Valid=0, FETCH issues target.
- Async reset mid-WAIT: Reset_L low between edges → outputs zero immediately; a subsequent Imem_RValid does not load IF/ID; fetch restarts at RESET_PC.
